// File: rtl/sseg_display_driver_if.sv
// Load/mode/status and segment/anode signals of the seven-segment display driver.
// The master drives the load side and the slave (the driver itself) drives status and display pins.
interface sseg_display_driver_if;
   logic [15:0] value;
   logic        dec;
   logic        load;
   logic        busy;
   logic        overflow;
   logic [6:0]  segments;
   logic [3:0]  anodes;

   modport master (
      output value,
      output dec,
      output load,
      input  busy,
      input  overflow,
      input  segments,
      input  anodes
   );

   modport slave (
      input  value,
      input  dec,
      input  load,
      output busy,
      output overflow,
      output segments,
      output anodes
   );
endinterface

// File: rtl/sseg_display_driver.sv
// 4-digit multiplexed seven-segment driver: hex or decimal display of a latched 16-bit value,
// with a sequential double-dabble converter for decimal mode and a free-running anode scan.
module sseg_display_driver #(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input logic                  clk,
   input logic                  reset,
   sseg_display_driver_if.slave bus
);

   localparam int unsigned CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned BIN_W      = 16;
   localparam int unsigned BCD_DIGITS = 5;
   localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
   localparam int unsigned CONV_W     = BCD_W + BIN_W;
   localparam int unsigned STEP_W     = 4;
   localparam int unsigned NUM_DIG    = 4;
   localparam int unsigned DIG_W      = 4;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned IDX_W      = 2;

   localparam logic [SEG_W-1:0]  GLYPH_ZERO = 7'b1000000;
   localparam logic [SEG_W-1:0]  GLYPH_DASH = 7'b0111111;
   localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONV,
      ST_COMMIT
   } state_t;

   state_t                          state_q;
   logic [BIN_W-1:0]                shift_q;
   logic [BCD_W-1:0]                bcd_q;
   logic [STEP_W-1:0]               step_q;
   logic                            busy_q;
   logic                            overflow_q;
   logic [NUM_DIG-1:0][DIG_W-1:0]   digits_q;
   logic                            dash_q;

   logic [CNT_W-1:0]                scan_cnt_q;
   logic [IDX_W-1:0]                digit_idx_q;
   logic [SEG_W-1:0]                segments_q;
   logic [NUM_DIG-1:0]              anodes_q;

   logic [BCD_W-1:0]                bcd_adj_c;
   logic [CONV_W-1:0]               conv_shift_c;
   logic                            scan_wrap_c;
   logic [IDX_W-1:0]                digit_idx_nxt_c;
   logic [SEG_W-1:0]                segments_nxt_c;

   function automatic logic [SEG_W-1:0] hex_glyph(input logic [DIG_W-1:0] d);
      logic [SEG_W-1:0] g;
      case (d)
         4'h0:    g = 7'b1000000;
         4'h1:    g = 7'b1111001;
         4'h2:    g = 7'b0100100;
         4'h3:    g = 7'b0110000;
         4'h4:    g = 7'b0011001;
         4'h5:    g = 7'b0010010;
         4'h6:    g = 7'b0000010;
         4'h7:    g = 7'b1111000;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0010000;
         4'hA:    g = 7'b0001000;
         4'hB:    g = 7'b0000011;
         4'hC:    g = 7'b1000110;
         4'hD:    g = 7'b0100001;
         4'hE:    g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   // Double-dabble step: add 3 to every BCD nibble >= 5, then shift {bcd, binary} left by one.
   always_comb begin
      bcd_adj_c = '0;
      for (int i = 0; i < int'(BCD_DIGITS); i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end else begin
            bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4];
         end
      end
      conv_shift_c = {bcd_adj_c, shift_q} << 1;
   end

   // Scan advance and the glyph for the digit that becomes active at the next edge.
   always_comb begin
      scan_wrap_c     = (scan_cnt_q == CNT_W'(REFRESH_DIV - 1));
      digit_idx_nxt_c = digit_idx_q;
      if (scan_wrap_c) begin
         digit_idx_nxt_c = digit_idx_q + IDX_W'(1);
      end
      segments_nxt_c = hex_glyph(digits_q[digit_idx_nxt_c]);
      if (dash_q) begin
         segments_nxt_c = GLYPH_DASH;
      end
   end

   // Load acceptance, decimal conversion FSM and display register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bcd_q      <= '0;
         step_q     <= '0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
         digits_q   <= '0;
         dash_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.load) begin
                  if (bus.dec) begin
                     shift_q <= bus.value;
                     bcd_q   <= '0;
                     step_q  <= '0;
                     busy_q  <= 1'b1;
                     state_q <= ST_CONV;
                  end else begin
                     digits_q   <= bus.value;
                     dash_q     <= 1'b0;
                     overflow_q <= 1'b0;
                  end
               end
            end
            ST_CONV: begin
               bcd_q   <= conv_shift_c[CONV_W-1:BIN_W];
               shift_q <= conv_shift_c[BIN_W-1:0];
               step_q  <= step_q + STEP_W'(1);
               if (step_q == LAST_STEP) begin
                  state_q <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               if (bcd_q[BCD_W-1 -: 4] != 4'd0) begin
                  dash_q     <= 1'b1;
                  overflow_q <= 1'b1;
               end else begin
                  digits_q   <= bcd_q[NUM_DIG*DIG_W-1:0];
                  dash_q     <= 1'b0;
                  overflow_q <= 1'b0;
               end
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Anode and segment outputs share one register stage so glyph and anode always match.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_cnt_q  <= '0;
         digit_idx_q <= '0;
         segments_q  <= GLYPH_ZERO;
         anodes_q    <= 4'b1110;
      end else begin
         scan_cnt_q  <= scan_wrap_c ? '0 : scan_cnt_q + CNT_W'(1);
         digit_idx_q <= digit_idx_nxt_c;
         segments_q  <= segments_nxt_c;
         anodes_q    <= ~(4'b0001 << digit_idx_nxt_c);
      end
   end

   assign bus.busy     = busy_q;
   assign bus.overflow = overflow_q;
   assign bus.segments = segments_q;
   assign bus.anodes   = anodes_q;

endmodule
